// File: rtl/prog_mem_arbiter.sv
// Program memory read-port arbiter: fetch vs debug, combinational grants, one read per cycle.
// A READ_LATENCY-deep tag pipeline routes each returned word to its issuer; fetch entries die on flush.
module prog_mem_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_halt,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  input  logic                  i_if_flush,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  output logic [ADDR_WIDTH-1:0] o_if_raddr,
  input  logic                  i_dbg_req,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rvalid,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_busy
);

  typedef struct packed {
    logic                  vld;
    logic                  is_dbg;
    logic [ADDR_WIDTH-1:0] addr;
  } tag_t;

  localparam logic [3:0] WAIT_CAP = 4'(MAX_WAIT);

  tag_t                  tag_q [READ_LATENCY];
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  if_ok;
  logic                  any_gnt;

  // Grants are suppressed while reset is high so every output reads zero immediately.
  always_comb begin
    if_ok     = i_if_req & ~i_halt & ~i_if_flush & ~i_reset;
    o_dbg_gnt = i_dbg_req & ~i_reset & (~if_ok | (wait_cnt == WAIT_CAP));
    o_if_gnt  = if_ok & ~o_dbg_gnt;
    any_gnt   = o_if_gnt | o_dbg_gnt;
    if (o_dbg_gnt)
      o_mem_addr = i_dbg_addr;
    else if (o_if_gnt)
      o_mem_addr = i_if_addr;
    else
      o_mem_addr = last_addr;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt  <= '0;
      last_addr <= '0;
    end else begin
      if (!i_dbg_req || o_dbg_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_CAP)
        wait_cnt <= wait_cnt + 4'd1;
      if (any_gnt)
        last_addr <= o_mem_addr;
    end
  end

  // Stage 0 never holds a fetch during a flush cycle, so only the shifted stages need masking.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < READ_LATENCY; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_t'{vld: any_gnt, is_dbg: o_dbg_gnt, addr: o_mem_addr};
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
        if (i_if_flush && !tag_q[i-1].is_dbg)
          tag_q[i].vld <= 1'b0;
      end
    end
  end

  always_comb begin
    o_busy = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++)
      o_busy = o_busy | tag_q[i].vld;
  end

  assign o_if_rvalid  = tag_q[READ_LATENCY-1].vld & ~tag_q[READ_LATENCY-1].is_dbg & ~i_if_flush;
  assign o_dbg_rvalid = tag_q[READ_LATENCY-1].vld & tag_q[READ_LATENCY-1].is_dbg;
  assign o_if_raddr   = tag_q[READ_LATENCY-1].addr;
  assign o_if_rdata   = i_mem_data;
  assign o_dbg_rdata  = i_mem_data;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: two instances (latency 2 and 1) share one stimulus stream
// and are checked against an issue-order response queue with due cycles.
module tb_prog_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        i_reset, i_halt, i_if_req, i_if_flush, i_dbg_req;
  logic [10:0] i_if_addr, i_dbg_addr;

  wire [1:0]        if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, busy;
  wire [1:0][10:0]  mem_addr, if_raddr;
  wire [1:0][31:0]  if_rdata, dbg_rdata;
  logic [31:0]      mem_data_a, mem_data_b;
  logic [10:0]      a_q1, a_q2, b_q1;

  function automatic logic [31:0] memval(input logic [10:0] a);
    return 32'h5A3C96E1 ^ {21'h0, a} ^ ({21'h0, a} << 16);
  endfunction

  prog_mem_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .READ_LATENCY(2), .MAX_WAIT(MAX_WAIT)) u_l2 (
    .i_clk(clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(if_gnt[0]), .o_if_rvalid(if_rvalid[0]), .o_if_rdata(if_rdata[0]), .o_if_raddr(if_raddr[0]),
    .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr),
    .o_dbg_gnt(dbg_gnt[0]), .o_dbg_rvalid(dbg_rvalid[0]), .o_dbg_rdata(dbg_rdata[0]),
    .o_mem_addr(mem_addr[0]), .i_mem_data(mem_data_a), .o_busy(busy[0]));

  prog_mem_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .READ_LATENCY(1), .MAX_WAIT(MAX_WAIT)) u_l1 (
    .i_clk(clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(if_gnt[1]), .o_if_rvalid(if_rvalid[1]), .o_if_rdata(if_rdata[1]), .o_if_raddr(if_raddr[1]),
    .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr),
    .o_dbg_gnt(dbg_gnt[1]), .o_dbg_rvalid(dbg_rvalid[1]), .o_dbg_rdata(dbg_rdata[1]),
    .o_mem_addr(mem_addr[1]), .i_mem_data(mem_data_b), .o_busy(busy[1]));

  // Program memories: registered address, plus one output register for the latency-2 part.
  always_ff @(posedge clk) begin
    a_q1 <= mem_addr[0];
    a_q2 <= a_q1;
    b_q1 <= mem_addr[1];
  end
  assign mem_data_a = memval(a_q2);
  assign mem_data_b = memval(b_q1);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          inst;
    int          due;
    bit          dbg;
    logic [10:0] addr;
  } resp_t;

  resp_t       exp_q[$];
  int          n_cmp, n_fail, cyc, wcnt;
  logic [10:0] last, if_a, dbg_a;
  bit          if_pend, dbg_pend;

  task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat=%0d cyc=%0d observed=%0h expected=%0h", tag, 2 - k, cyc, obs, exp);
    end
  endtask

  task automatic do_cycle();
    bit          eg_if, eg_dbg, fok, hit, bexp;
    resp_t       e, nq[$];
    logic [10:0] ea;
    i_if_req   = if_pend;
    i_if_addr  = if_a;
    i_dbg_req  = dbg_pend;
    i_dbg_addr = dbg_a;
    @(negedge clk);
    eg_if  = 1'b0;
    eg_dbg = 1'b0;
    if (!i_reset) begin
      fok = if_pend && !i_halt && !i_if_flush;
      if (dbg_pend && (!fok || wcnt == MAX_WAIT)) eg_dbg = 1'b1;
      else if (fok) eg_if = 1'b1;
    end
    ea = eg_dbg ? dbg_a : (eg_if ? if_a : last);
    for (int k = 0; k < 2; k++) begin
      hit  = 1'b0;
      bexp = 1'b0;
      e    = '{inst: k, due: 0, dbg: 1'b0, addr: 11'h0};
      foreach (exp_q[j]) begin
        if (exp_q[j].inst == k) begin
          bexp = 1'b1;
          if (exp_q[j].due == cyc) begin
            hit = 1'b1;
            e   = exp_q[j];
          end
        end
      end
      chk(k, "if_gnt", 32'(if_gnt[k]), 32'(eg_if));
      chk(k, "dbg_gnt", 32'(dbg_gnt[k]), 32'(eg_dbg));
      chk(k, "mem_addr", 32'(mem_addr[k]), 32'(ea));
      chk(k, "if_rvalid", 32'(if_rvalid[k]), 32'(hit && !e.dbg && !i_if_flush));
      chk(k, "dbg_rvalid", 32'(dbg_rvalid[k]), 32'(hit && e.dbg));
      chk(k, "busy", 32'(busy[k]), 32'(bexp));
      if (hit && !e.dbg && !i_if_flush) begin
        chk(k, "if_raddr", 32'(if_raddr[k]), 32'(e.addr));
        chk(k, "if_rdata", if_rdata[k], memval(e.addr));
      end
      if (hit && e.dbg)
        chk(k, "dbg_rdata", dbg_rdata[k], memval(e.addr));
    end
    @(posedge clk);
    if (i_reset) begin
      exp_q.delete();
      wcnt = 0;
      last = 11'h0;
    end else begin
      foreach (exp_q[j])
        if (exp_q[j].due != cyc && !(i_if_flush && !exp_q[j].dbg))
          nq.push_back(exp_q[j]);
      exp_q = nq;
      if (eg_if || eg_dbg) begin
        exp_q.push_back('{inst: 0, due: cyc + 2, dbg: eg_dbg, addr: ea});
        exp_q.push_back('{inst: 1, due: cyc + 1, dbg: eg_dbg, addr: ea});
        last = ea;
      end
      if (!dbg_pend || eg_dbg) wcnt = 0;
      else if (wcnt < MAX_WAIT) wcnt++;
    end
    if (eg_if) if_pend = 1'b0;
    if (eg_dbg) dbg_pend = 1'b0;
    cyc++;
    #1;
  endtask

  // Reset lands between edges; everything must drop before the next clock.
  task automatic reset_mid();
    i_if_req   = if_pend;
    i_if_addr  = if_a;
    i_dbg_req  = dbg_pend;
    i_dbg_addr = dbg_a;
    #2;
    i_reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_if_gnt", 32'(if_gnt[k]), 32'h0);
      chk(k, "rst_dbg_gnt", 32'(dbg_gnt[k]), 32'h0);
      chk(k, "rst_if_rvalid", 32'(if_rvalid[k]), 32'h0);
      chk(k, "rst_dbg_rvalid", 32'(dbg_rvalid[k]), 32'h0);
      chk(k, "rst_busy", 32'(busy[k]), 32'h0);
      chk(k, "rst_mem_addr", 32'(mem_addr[k]), 32'h0);
    end
    exp_q.delete();
    wcnt = 0;
    last = 11'h0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; wcnt = 0; last = 11'h0;
    if_pend = 1'b0; dbg_pend = 1'b0; if_a = 11'h0; dbg_a = 11'h0;
    i_reset = 1'b0; i_halt = 1'b0; i_if_flush = 1'b0;
    i_if_req = 1'b0; i_dbg_req = 1'b0; i_if_addr = 11'h0; i_dbg_addr = 11'h0;
    #1 i_reset = 1'b1;
    if_pend = 1'b1;
    do_cycle();
    do_cycle();
    i_reset = 1'b0;
    if_pend = 1'b0;

    // Sequential fetches 0..3.
    for (int k = 0; k < 4; k++) begin
      if_pend = 1'b1;
      if_a    = 11'(k);
      do_cycle();
    end
    repeat (3) do_cycle();

    // Debug starves behind fetch until the wait cap forces it through.
    dbg_pend = 1'b1;
    dbg_a    = 11'h010;
    for (int k = 0; k < 8; k++) begin
      if (!if_pend) begin
        if_pend = 1'b1;
        if_a    = 11'(32 + k);
      end
      do_cycle();
    end
    repeat (3) do_cycle();

    // Flush with fetches 5 and 6 in flight while debug 7 issues.
    if_pend = 1'b1; if_a = 11'd5; do_cycle();
    if_pend = 1'b1; if_a = 11'd6; do_cycle();
    if_pend = 1'b1; if_a = 11'd8;
    dbg_pend = 1'b1; dbg_a = 11'd7;
    i_if_flush = 1'b1;
    do_cycle();
    i_if_flush = 1'b0;
    repeat (4) do_cycle();

    // Halt: only debug is served; fetch resumes once halt drops.
    i_halt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_pend = 1'b1;
      if_a    = 11'h300;
      if (!dbg_pend) begin
        dbg_pend = 1'b1;
        dbg_a    = 11'(64 + k);
      end
      do_cycle();
    end
    i_halt = 1'b0;
    do_cycle();
    repeat (3) do_cycle();

    // Alternating debug/fetch grants via halt toggling.
    for (int k = 0; k < 8; k++) begin
      if (!if_pend) begin if_pend = 1'b1; if_a = 11'(128 + k); end
      if (!dbg_pend) begin dbg_pend = 1'b1; dbg_a = 11'(256 + k); end
      i_halt = k[0];
      do_cycle();
    end
    i_halt = 1'b0;
    repeat (3) do_cycle();

    // Asynchronous reset with two reads in flight.
    if_pend = 1'b1; if_a = 11'h100; do_cycle();
    if_pend = 1'b1; if_a = 11'h101; do_cycle();
    reset_mid();
    do_cycle();
    i_reset = 1'b0;
    repeat (3) do_cycle();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1'b1;
        if_a    = 11'($urandom_range(0, 2047));
      end
      if (!dbg_pend && $urandom_range(0, 3) == 0) begin
        dbg_pend = 1'b1;
        dbg_a    = 11'($urandom_range(0, 2047));
      end
      if ($urandom_range(0, 9) == 0) i_halt = ~i_halt;
      i_if_flush = ($urandom_range(0, 6) == 0);
      do_cycle();
    end
    i_if_flush = 1'b0;
    i_halt     = 1'b0;
    repeat (4) do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem_arbiter.md
Name: prog_mem_arbiter

Overview:
Sole owner of the program memory read port. Arbitrates the instruction-fetch requester (IF stage) and the debug-unit requester (program dump and verify over UART) onto the single address bus. Tracks the fixed read latency of the memory with a tag pipeline so each returned word is routed to the requester that issued it. Supports IF flush on branch/jump and CPU halt.

Parameters:
ADDR_WIDTH, 11, program memory word-address width
DATA_WIDTH, 32, instruction word width
READ_LATENCY, 2, clock edges from address sample to valid i_mem_data; legal values 1 or 2
MAX_WAIT, 4, consecutive cycles debug may lose to fetch before it is forced to win (1..15)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_halt  in  1  CPU halted; fetch is never granted while high
i_if_req  in  1  fetch request; held until granted
i_if_addr  in  ADDR_WIDTH  fetch address; stable while i_if_req is high
i_if_flush  in  1  kill all in-flight fetch reads
o_if_gnt  out  1  fetch request accepted this cycle
o_if_rvalid  out  1  fetch data valid
o_if_rdata  out  DATA_WIDTH  fetch instruction
o_if_raddr  out  ADDR_WIDTH  address of o_if_rdata
i_dbg_req  in  1  debug read request; held until granted
i_dbg_addr  in  ADDR_WIDTH  debug address
o_dbg_gnt  out  1  debug request accepted this cycle
o_dbg_rvalid  out  1  debug data valid
o_dbg_rdata  out  DATA_WIDTH  debug data
o_mem_addr  out  ADDR_WIDTH  to program memory address input
i_mem_data  in  DATA_WIDTH  from program memory data output
o_busy  out  1  any read in flight

Behaviour:
- Reset (async, high): clears all grants, rvalids, tag pipeline, wait counter, and the last-address register. o_mem_addr=0, o_busy=0. A read in flight when reset asserts is discarded and never reported.
- Grants are combinational within the same cycle. At most one grant per cycle. The request is accepted at the rising edge that ends the grant cycle.
- Priority:
  - i_halt=1: debug wins whenever it requests.
  - Otherwise fetch wins, except debug wins when wait_cnt==MAX_WAIT.
  - If i_if_flush=1, fetch is not granted that cycle; debug may be granted.
- wait_cnt (4 bits):
  - Increments each cycle debug requests and is not granted.
  - Clears on a debug grant or whenever i_dbg_req=0.
  - Saturates at MAX_WAIT.
- o_mem_addr = address of the granted requester. With no grant, it holds the last granted address from a register. It never goes X.
- Tag pipeline: READ_LATENCY stages of {valid, is_dbg, addr}. Stage 0 loads on each edge (valid=any grant). The final stage aligns with i_mem_data.
  - o_if_rvalid = last.valid & ~last.is_dbg & ~i_if_flush
  - o_dbg_rvalid = last.valid & last.is_dbg
  - rdata outputs = i_mem_data, unregistered; o_if_raddr = last.addr.
- Flush: when i_if_flush=1, every stage with is_dbg=0 is invalidated on that edge. Debug entries are unaffected. A fetch reaching the output in the flush cycle is suppressed.
- Back-to-back grants are allowed every cycle. Throughput is 1 read/cycle; responses return in issue order.
- o_busy = OR of the valid bits of all stages.
- Addresses are word addresses. No wrap handling is needed beyond natural ADDR_WIDTH overflow, which is the requester's concern.

Test Plan:
1. Reset release, i_if_req=1 with addresses 0,1,2,3 on consecutive cycles, READ_LATENCY=2 -> o_if_gnt high for 4 cycles; o_if_rvalid high 2 cycles after each grant with raddr 0..3 and rdata=mem[0..3]; o_dbg_rvalid never high.
2. Fetch requests continuously, debug requests addr 0x10 from cycle 0, MAX_WAIT=4 -> fetch granted cycles 0-3, debug granted cycle 4, fetch resumes cycle 5; o_dbg_rdata=mem[0x10] at cycle 6.
3. Fetches of 5 and 6 issued, then debug of 7, then i_if_flush pulsed for one cycle while 5 and 6 are in flight -> no o_if_rvalid for 5 or 6; o_dbg_rvalid still returns mem[7]; no fetch grant in the flush cycle.
4. i_halt=1 with both requesting -> only o_dbg_gnt asserts; after i_halt falls, fetch is granted the next cycle.
5. i_reset asserted asynchronously mid-cycle with 2 reads in flight -> all outputs 0 immediately; no rvalid after reset release until a new grant has travelled through the pipeline.
6. READ_LATENCY=1, alternating fetch/debug grants -> each rvalid appears exactly 1 cycle after its grant and is routed to the correct requester.
